// File: rtl/io_pkg.sv
// Shared types and defaults for the console I/O responder.
package io_pkg;

  localparam int unsigned TX_DEPTH_DEF  = 16;
  localparam int unsigned RX_DEPTH_DEF  = 16;
  localparam int unsigned IO_BYTE_W     = 8;
  localparam int unsigned IO_WORD_BYTES = 4;
  localparam int unsigned IO_DATA_W     = 32;

  typedef logic [IO_BYTE_W-1:0] io_byte_t;
  typedef logic [IO_WORD_BYTES-1:0][IO_BYTE_W-1:0] io_window_t;

  // Entry 0 of the window is the oldest byte and lands in the low lane.
  function automatic logic [IO_DATA_W-1:0] pack_le(input io_window_t w);
    return IO_DATA_W'(w);
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous byte FIFO with a four-entry head window and 1- or 4-entry pops.
module io_fifo
  import io_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned POP_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  io_byte_t               push_data_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output io_window_t             head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  io_byte_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  // Callers gate push with !full and pop with count >= POP_W.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_i) - (pop_i ? CW'(POP_W) : CW'(0));
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(POP_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Head window wraps with the read pointer.
  always_comb begin
    head_o = '0;
    for (int k = 0; k < int'(IO_WORD_BYTES); k++) begin
      head_o[k] = mem_q[rd_ptr_q + AW'(k)];
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == CW'(0));

endmodule

// File: rtl/io_responder.sv
// Core-facing console I/O responder: TX/RX byte FIFOs between core and UART.
// IO_WORD_PACK_EN: serve input requests as little-endian 4-byte words.
module io_responder
  import io_pkg::*;
#(
  parameter int unsigned TX_DEPTH = TX_DEPTH_DEF,
  parameter int unsigned RX_DEPTH = RX_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 out_issued,
  input  logic [IO_DATA_W-1:0] out_data,
  output logic                 out_stall,
  input  logic                 in_issued,
  output logic                 in_stall,
  output logic [IO_DATA_W-1:0] in_data,
  output logic [IO_BYTE_W-1:0] tx_byte,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [IO_BYTE_W-1:0] rx_byte,
  input  logic                 rx_valid,
  output logic                 rx_overflow
);

  localparam int unsigned TCW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RCW = $clog2(RX_DEPTH) + 1;
`ifdef IO_WORD_PACK_EN
  localparam int unsigned RX_POP_W = IO_WORD_BYTES;
`else
  localparam int unsigned RX_POP_W = 1;
`endif

  logic [TCW-1:0] tx_count;
  logic           tx_full, tx_empty, tx_push, tx_pop;
  io_window_t     tx_head;
  logic [RCW-1:0] rx_count;
  logic           rx_full, rx_empty, rx_push, rx_pop, rx_ok;
  io_window_t     rx_head;
  logic           ovf_q, ovf_d;

  assign tx_push = out_issued && !tx_full;
  assign tx_pop  = tx_valid && tx_ready;

  io_fifo #(.DEPTH(TX_DEPTH), .POP_W(1)) u_tx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (tx_push),
    .push_data_i (io_byte_t'(out_data[IO_BYTE_W-1:0])),
    .pop_i       (tx_pop),
    .count_o     (tx_count),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .head_o      (tx_head)
  );

  assign out_stall = out_issued && tx_full;
  assign tx_valid  = !tx_empty;
  assign tx_byte   = tx_head[0];

  assign rx_push = rx_valid && !rx_full;
  assign rx_pop  = in_issued && rx_ok;

  io_fifo #(.DEPTH(RX_DEPTH), .POP_W(RX_POP_W)) u_rx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rx_push),
    .push_data_i (rx_byte),
    .pop_i       (rx_pop),
    .count_o     (rx_count),
    .full_o      (rx_full),
    .empty_o     (rx_empty),
    .head_o      (rx_head)
  );

  // Serve decisions look only at registered counts; a same-cycle push never helps.
`ifdef IO_WORD_PACK_EN
  logic unused_rx;
  assign rx_ok     = (rx_count >= RCW'(IO_WORD_BYTES));
  assign in_data   = rx_pop ? pack_le(rx_head) : '0;
  assign unused_rx = rx_empty;
`else
  logic unused_rx;
  assign rx_ok     = !rx_empty;
  assign in_data   = rx_pop ? IO_DATA_W'(rx_head[0]) : '0;
  assign unused_rx = ^{rx_count, rx_head[IO_WORD_BYTES-1:1]};
`endif

  assign in_stall = in_issued && !rx_ok;

  logic unused_tx;
  assign unused_tx = ^{tx_count, tx_head[IO_WORD_BYTES-1:1], out_data[IO_DATA_W-1:IO_BYTE_W]};

  // Overflow is sticky until reset.
  always_comb begin
    ovf_d = ovf_q;
    if (rx_valid && rx_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign rx_overflow = ovf_q;

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: TX vector table plus RX/overflow/full sequences.
module tb_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_issued;
  logic [31:0] out_data;
  logic        out_stall;
  logic        in_issued;
  logic        in_stall;
  logic [31:0] in_data;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_overflow;

  int checks = 0;
  int errors = 0;

  io_responder #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .out_issued  (out_issued),
    .out_data    (out_data),
    .out_stall   (out_stall),
    .in_issued   (in_issued),
    .in_stall    (in_stall),
    .in_data     (in_data),
    .tx_byte     (tx_byte),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_overflow (rx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        oi;
    logic [31:0] od;
    logic        txr;
    logic        ii;
    logic        rxv;
    logic [7:0]  rxb;
    logic        e_os;
    logic        e_is;
    logic [31:0] e_id;
    logic        e_tv;
    logic [7:0]  e_tb;
    logic        e_ovf;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic oi, input logic [31:0] od,
                              input logic txr, input logic ii, input logic rxv,
                              input logic [7:0] rxb, input logic e_os, input logic e_is,
                              input logic [31:0] e_id, input logic e_tv,
                              input logic [7:0] e_tb, input logic e_ovf);
    vec_t v;
    v.rst = r; v.oi = oi; v.od = od; v.txr = txr; v.ii = ii; v.rxv = rxv; v.rxb = rxb;
    v.e_os = e_os; v.e_is = e_is; v.e_id = e_id; v.e_tv = e_tv; v.e_tb = e_tb;
    v.e_ovf = e_ovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; out_issued = 1'b0; out_data = '0; tx_ready = 1'b0;
    in_issued = 1'b0; rx_valid = 1'b0; rx_byte = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_valid = 1'b1; rx_byte = b;
    cyc();
    rx_valid = 1'b0;
  endtask

  vec_t vt [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          rst oi od            txr ii rxv rxb   os is id  tv tb     ovf
    vt[0]  = mk(1, 0, 32'h0,        0,  1, 0,  8'h0, 0, 1, 0,  0, 8'h00, 0);
    vt[1]  = mk(0, 1, 32'h12345641, 1,  0, 0,  8'h0, 0, 0, 0,  0, 8'h00, 0);
    vt[2]  = mk(0, 0, 32'h0,        1,  0, 0,  8'h0, 0, 0, 0,  1, 8'h41, 0);
    vt[3]  = mk(0, 0, 32'h0,        1,  0, 0,  8'h0, 0, 0, 0,  0, 8'h00, 0);
    vt[4]  = mk(0, 1, 32'hFFFFFFA5, 0,  0, 0,  8'h0, 0, 0, 0,  0, 8'h00, 0);
    vt[5]  = mk(0, 1, 32'h0000005C, 1,  0, 0,  8'h0, 0, 0, 0,  1, 8'hA5, 0);
    vt[6]  = mk(0, 0, 32'h0,        0,  0, 0,  8'h0, 0, 0, 0,  1, 8'h5C, 0);
    vt[7]  = mk(0, 0, 32'h0,        1,  0, 0,  8'h0, 0, 0, 0,  1, 8'h5C, 0);
    vt[8]  = mk(0, 0, 32'h0,        1,  0, 0,  8'h0, 0, 0, 0,  0, 8'h00, 0);
    vt[9]  = mk(0, 1, 32'h00000077, 0,  0, 0,  8'h0, 0, 0, 0,  0, 8'h00, 0);
    vt[10] = mk(1, 0, 32'h0,        0,  0, 0,  8'h0, 0, 0, 0,  1, 8'h77, 0);
    vt[11] = mk(0, 0, 32'h0,        0,  0, 0,  8'h0, 0, 0, 0,  0, 8'h00, 0);

    idle();
    #1;
    do_reset();

    // Table: reset values, TX latency, push+pop at count 1, mid-run reset.
    for (int i = 0; i < 12; i++) begin
      rst = vt[i].rst; out_issued = vt[i].oi; out_data = vt[i].od; tx_ready = vt[i].txr;
      in_issued = vt[i].ii; rx_valid = vt[i].rxv; rx_byte = vt[i].rxb;
      #1;
      chk($sformatf("vec%0d out_stall", i), 32'(out_stall), 32'(vt[i].e_os));
      chk($sformatf("vec%0d in_stall", i), 32'(in_stall), 32'(vt[i].e_is));
      chk($sformatf("vec%0d in_data", i), in_data, vt[i].e_id);
      chk($sformatf("vec%0d tx_valid", i), 32'(tx_valid), 32'(vt[i].e_tv));
      if (vt[i].e_tv) chk($sformatf("vec%0d tx_byte", i), 32'(tx_byte), 32'(vt[i].e_tb));
      chk($sformatf("vec%0d rx_overflow", i), 32'(rx_overflow), 32'(vt[i].e_ovf));
      cyc();
    end

    // TX full: 16 accepted, 17th stalls, no bypass when a pop coincides.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      out_issued = 1'b1; out_data = 32'(i);
      #1;
      chk($sformatf("txfill%0d out_stall", i), 32'(out_stall), 32'd0);
      cyc();
    end
    out_issued = 1'b1; out_data = 32'h10;
    #1;
    chk("txfull out_stall", 32'(out_stall), 32'd1);
    cyc();
    tx_ready = 1'b1;
    #1;
    chk("txfull_pop out_stall", 32'(out_stall), 32'd1);
    chk("txfull_pop tx_byte", 32'(tx_byte), 32'h00);
    cyc();
    #1;
    chk("txaccept out_stall", 32'(out_stall), 32'd0);
    chk("txaccept tx_byte", 32'(tx_byte), 32'h01);
    cyc();
    out_issued = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      #1;
      chk($sformatf("txdrain%0d tx_valid", i), 32'(tx_valid), 32'd1);
      chk($sformatf("txdrain%0d tx_byte", i), 32'(tx_byte), 32'(i));
      cyc();
    end
    #1;
    chk("txdrain_end tx_valid", 32'(tx_valid), 32'd0);

`ifndef IO_WORD_PACK_EN
    // Byte serve with no same-cycle bypass.
    do_reset();
    in_issued = 1'b1; rx_valid = 1'b1; rx_byte = 8'h5A;
    #1;
    chk("rx_empty in_stall", 32'(in_stall), 32'd1);
    chk("rx_empty in_data", in_data, 32'h0);
    cyc();
    rx_valid = 1'b0;
    #1;
    chk("rx_serve in_stall", 32'(in_stall), 32'd0);
    chk("rx_serve in_data", in_data, 32'h0000005A);
    cyc();
    #1;
    chk("rx_after in_stall", 32'(in_stall), 32'd1);
    chk("rx_after in_data", in_data, 32'h0);

    // Overflow on the 17th push; first 16 bytes intact.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      #1;
      chk($sformatf("ovf_pre%0d", i), 32'(rx_overflow), 32'd0);
      rx_push(8'(8'h80 + i));
    end
    #1;
    chk("ovf_set", 32'(rx_overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      in_issued = 1'b1;
      #1;
      chk($sformatf("ovf_rd%0d in_stall", i), 32'(in_stall), 32'd0);
      chk($sformatf("ovf_rd%0d in_data", i), in_data, 32'(8'(8'h80 + i)));
      cyc();
    end
    #1;
    chk("ovf_rd_end in_stall", 32'(in_stall), 32'd1);
    chk("ovf_sticky", 32'(rx_overflow), 32'd1);
    in_issued = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("ovf_clear", 32'(rx_overflow), 32'd0);

    // Push and serve together at count 5.
    do_reset();
    for (int i = 1; i <= 5; i++) rx_push(8'(i));
    in_issued = 1'b1; rx_valid = 1'b1; rx_byte = 8'h06;
    #1;
    chk("simul in_data", in_data, 32'h01);
    cyc();
    rx_valid = 1'b0;
    for (int i = 2; i <= 6; i++) begin
      #1;
      chk($sformatf("simul_rd%0d in_stall", i), 32'(in_stall), 32'd0);
      chk($sformatf("simul_rd%0d in_data", i), in_data, 32'(i));
      cyc();
    end
    #1;
    chk("simul_end in_stall", 32'(in_stall), 32'd1);
`else
    // Word serve needs four entries; the 4th push does not bypass.
    do_reset();
    rx_push(8'h11); rx_push(8'h22); rx_push(8'h33);
    in_issued = 1'b1; rx_valid = 1'b1; rx_byte = 8'h44;
    #1;
    chk("w3 in_stall", 32'(in_stall), 32'd1);
    chk("w3 in_data", in_data, 32'h0);
    cyc();
    rx_valid = 1'b0;
    #1;
    chk("w4 in_stall", 32'(in_stall), 32'd0);
    chk("w4 in_data", in_data, 32'h44332211);
    cyc();
    #1;
    chk("w4_after in_stall", 32'(in_stall), 32'd1);

    // Overflow on the 17th push; four words read back intact.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      #1;
      chk($sformatf("wovf_pre%0d", i), 32'(rx_overflow), 32'd0);
      rx_push(8'(8'h80 + i));
    end
    #1;
    chk("wovf_set", 32'(rx_overflow), 32'd1);
    for (int j = 0; j < 4; j++) begin
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(8'h80 + 4*j + k);
      in_issued = 1'b1;
      #1;
      chk($sformatf("wovf_rd%0d in_stall", j), 32'(in_stall), 32'd0);
      chk($sformatf("wovf_rd%0d in_data", j), in_data, w);
      cyc();
    end
    #1;
    chk("wovf_end in_stall", 32'(in_stall), 32'd1);
    in_issued = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("wovf_clear", 32'(rx_overflow), 32'd0);

    // Push and word serve together at count 5.
    do_reset();
    for (int i = 1; i <= 5; i++) rx_push(8'(i));
    in_issued = 1'b1; rx_valid = 1'b1; rx_byte = 8'h06;
    #1;
    chk("wsimul in_data", in_data, 32'h04030201);
    cyc();
    rx_valid = 1'b0;
    #1;
    chk("wsimul_2 in_stall", 32'(in_stall), 32'd1);
    in_issued = 1'b0;
    rx_push(8'h07); rx_push(8'h08);
    in_issued = 1'b1;
    #1;
    chk("wsimul_rd in_stall", 32'(in_stall), 32'd0);
    chk("wsimul_rd in_data", in_data, 32'h08070605);
    cyc();
    #1;
    chk("wsimul_end in_stall", 32'(in_stall), 32'd1);
`endif

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
